i2c_cmd_seq: RTL and testbench
==============================

// Module: i2c_cmd_seq
// PURPOSE
//  Multi-script I2C command sequencer: the parametrised successor to the single-script OLED init controller.
//  Holds NUM_SEQ independent command scripts (base/length) in a shared external byte ROM.
//  Each script is started by its own trigger; the block streams that script's bytes to an i2c_master write port.
//  Adds pending-trigger queuing, fixed-priority arbitration, NACK retry, abort, and inter-command delay.
//  Sits between the panel control logic (triggers) and i2c_master (ADDR_BYTES=1, DATA_BYTES=1).
// PARAMETERS
//  NUM_SEQ    4       number of scripts/trigger channels (1..8); IDW = max(1,$clog2(NUM_SEQ))
//  ROM_AW     6       command ROM address width; script base/len fields are ROM_AW bits
//  DELAY_W    16      width of the inter-command delay counter
//  DELAY_CYC  50000   idle clk cycles after each completed byte (< 2**DELAY_W); 0 = no delay
//  MAX_RETRY  2       re-sends of one byte after NACK before error (0 = none)
//  CTRL_BYTE  8'h00   value driven on i2c_reg_addr (panel control byte: command stream)
// PORTS
//  clk           in   1            system clock
//  reset         in   1            synchronous, active-high reset
//  trig          in   NUM_SEQ      level inputs; rising edge (2-FF synced) requests script i
//  abort         in   1            cancel running script
//  seq_base      in   NUM_SEQ*ROM_AW  script i start address = bits [i*ROM_AW +: ROM_AW]
//  seq_len       in   NUM_SEQ*ROM_AW  script i byte count, same packing; 0 = empty script
//  rom_rd_en     out  1            ROM read strobe; rom_data valid the following cycle
//  rom_addr      out  ROM_AW       ROM address
//  rom_data      in   8            ROM read data
//  i2c_write_en  out  1            one-cycle write request to i2c_master
//  i2c_reg_addr  out  8            constant CTRL_BYTE
//  i2c_data      out  8            command byte, stable from write_en until i2c_done
//  i2c_done      in   1            one-cycle pulse: transaction finished
//  i2c_nack      in   1            sampled with i2c_done; 1 = slave NACKed
//  busy          out  1            high in every state except IDLE
//  active_seq    out  IDW          index of script running (valid while busy)
//  done          out  1            one-cycle pulse: script completed normally
//  error         out  1            one-cycle pulse: retries exhausted
// BEHAVIOUR
//  Reset: all outputs 0; rom_addr=0; pending=0; trigger sync FFs=0; state IDLE.
//   Reset mid-operation returns to IDLE next cycle; the block is not required to complete the current I2C transaction.
//  Trigger path: edge on trig[i] sets pending[i] 2 cycles later. Repeated edges while pending merge into one request.
//   Edges arriving while busy queue for later service. pending[i] clears on the cycle script i is selected.
//  IDLE: if pending!=0, select lowest set index k; load addr=base[k], idx=0, retry=0, active_seq=k.
//   Go to DONE if len[k]==0, else FETCH.
//  FETCH (1 cyc): rom_rd_en=1, rom_addr=addr -> ISSUE.
//  ISSUE (1 cyc): latch rom_data into i2c_data -> WRITE.
//  WRITE (1 cyc): i2c_write_en=1 -> WAIT.
//  WAIT: hold until i2c_done.
//   nack=0 -> SLEEP with cnt=0.
//   nack=1 and retry<MAX_RETRY -> retry++, WRITE; the same byte is re-sent with no re-fetch.
//   nack=1 and retry==MAX_RETRY -> ERR.
//  SLEEP: count DELAY_CYC cycles, then:
//   if idx==len-1 -> DONE;
//   else idx++, addr=addr+1 (wraps mod 2**ROM_AW), retry=0 -> FETCH.
//  DONE / ERR (1 cyc): pulse done / error -> IDLE. done and error are never high together.
//  abort:
//   in FETCH/ISSUE/WRITE/SLEEP: -> IDLE next cycle, with no done/error pulse. WRITE abort suppresses write_en.
//   in WAIT: latched; honoured after i2c_done (no retry).
//   pending requests for other scripts are kept.
//  Byte throughput: 3 cycles + I2C time + DELAY_CYC per byte. Trigger->first rom_rd_en = 4 cycles from the trig edge.
//  busy is registered from state: it goes high the cycle after IDLE selects, and low in the cycle after DONE/ERR.
// TESTING
//  (bench: DELAY_CYC=4, ROM_AW=4, i2c_master model acks after 20 cycles)
//  1. ROM[0..2]=AE,D5,80; base0=0, len0=3; pulse trig[0].
//     -> 3 write_en pulses with data AE,D5,80, each >=4 cycles apart after done;
//        one done pulse; busy falls.
//  2. trig[2] and trig[1] rise in the same cycle.
//     -> script 1 runs fully (active_seq=1), then script 2 (active_seq=2); two done pulses.
//  3. NACK twice, then ACK on byte 0.
//     -> 3 write_en for the same byte, then script continues.
//     Three NACKs -> error pulse, no done, IDLE, rom_addr not advanced.
//  4. len=0 script triggered.
//     -> done within 3 cycles of selection; no rom_rd_en, no write_en.
//  5. base=14, len=4.
//     -> rom_addr sequence 14,15,0,1.
//  6. reset asserted in WAIT, then abort asserted in SLEEP of a new run.
//     -> outputs 0 and pending cleared on reset; abort returns to IDLE with no done.
//        A queued trig[3] then runs.

Source files
------------

// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: runs one of NUM_SEQ byte scripts from a shared ROM into an
// i2c_master write port, with trigger queuing, fixed priority and NACK retry.
// Ports: clk/reset, trig/abort controls, per-script seq_base/seq_len tables,
// ROM read port (rom_rd_en/rom_addr/rom_data), i2c_master write port
// (i2c_write_en/i2c_reg_addr/i2c_data/i2c_done/i2c_nack), and status
// (busy/active_seq/done/error).
module i2c_cmd_seq #(
    parameter int         NUM_SEQ   = 4,
    parameter int         ROM_AW    = 6,
    parameter int         DELAY_W   = 16,
    parameter int         DELAY_CYC = 50000,
    parameter int         MAX_RETRY = 2,
    parameter logic [7:0] CTRL_BYTE = 8'h00,
    parameter int         IDW       = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SEQ-1:0]        trig,
    input  logic                      abort,
    input  logic [NUM_SEQ*ROM_AW-1:0] seq_base,
    input  logic [NUM_SEQ*ROM_AW-1:0] seq_len,
    output logic                      rom_rd_en,
    output logic [ROM_AW-1:0]         rom_addr,
    input  logic [7:0]                rom_data,
    output logic                      i2c_write_en,
    output logic [7:0]                i2c_reg_addr,
    output logic [7:0]                i2c_data,
    input  logic                      i2c_done,
    input  logic                      i2c_nack,
    output logic                      busy,
    output logic [IDW-1:0]            active_seq,
    output logic                      done,
    output logic                      error
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [DELAY_W-1:0] DLY_LAST =
        (DELAY_CYC > 1) ? DELAY_W'(DELAY_CYC - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WRITE,
        S_WAIT, S_SLEEP, S_DONE, S_ERR
    } state_t;

    state_t state, state_n;

    logic [NUM_SEQ-1:0] sync1, sync2, sync3;
    logic [NUM_SEQ-1:0] pending, pending_clr, rise;

    logic [ROM_AW-1:0]  addr_q, addr_n;
    logic [ROM_AW-1:0]  idx_q, idx_n;
    logic [ROM_AW-1:0]  len_q, len_n;
    logic [RW-1:0]      retry_q, retry_n;
    logic [DELAY_W-1:0] cnt_q, cnt_n;
    logic [IDW-1:0]     seq_q, seq_n;
    logic [7:0]         data_q, data_n;
    logic               abort_q, abort_n;
    logic               busy_q;

    logic [IDW-1:0]     sel;
    logic [ROM_AW-1:0]  base_sel, len_sel;
    logic               dly_end, last_byte;

    assign rise = sync2 & ~sync3;

    // Lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_SEQ - 1; i >= 0; i--) begin
            if (pending[i]) sel = IDW'(i);
        end
    end

    assign base_sel  = seq_base[int'(sel) * ROM_AW +: ROM_AW];
    assign len_sel   = seq_len[int'(sel) * ROM_AW +: ROM_AW];
    // A zero or one-cycle delay still spends a single cycle in SLEEP.
    assign dly_end   = (DELAY_CYC <= 1) || (cnt_q == DLY_LAST);
    assign last_byte = (idx_q == len_q - ROM_AW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            sync1   <= '0;
            sync2   <= '0;
            sync3   <= '0;
            pending <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
            data_q  <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            sync1   <= trig;
            sync2   <= sync1;
            sync3   <= sync2;
            // A fresh edge on the channel being selected survives the clear.
            pending <= (pending & ~pending_clr) | rise;
            addr_q  <= addr_n;
            idx_q   <= idx_n;
            len_q   <= len_n;
            retry_q <= retry_n;
            cnt_q   <= cnt_n;
            seq_q   <= seq_n;
            data_q  <= data_n;
            abort_q <= abort_n;
            busy_q  <= (state_n != S_IDLE);
        end
    end

    always_comb begin
        state_n      = state;
        addr_n       = addr_q;
        idx_n        = idx_q;
        len_n        = len_q;
        retry_n      = retry_q;
        cnt_n        = cnt_q;
        seq_n        = seq_q;
        data_n       = data_q;
        abort_n      = abort_q;
        pending_clr  = '0;
        rom_rd_en    = 1'b0;
        i2c_write_en = 1'b0;
        done         = 1'b0;
        error        = 1'b0;

        unique case (state)
            S_IDLE: begin
                abort_n = 1'b0;
                if (|pending) begin
                    pending_clr[sel] = 1'b1;
                    addr_n  = base_sel;
                    idx_n   = '0;
                    len_n   = len_sel;
                    retry_n = '0;
                    seq_n   = sel;
                    state_n = (len_sel == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                rom_rd_en = 1'b1;
                state_n   = abort ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                data_n  = rom_data;
                state_n = abort ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                i2c_write_en = ~abort;
                state_n      = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // The bus transaction cannot be cut short; remember the
                // abort and act on it once the master reports completion.
                if (abort) abort_n = 1'b1;
                if (i2c_done) begin
                    abort_n = 1'b0;
                    if (abort_q || abort) begin
                        state_n = S_IDLE;
                    end else if (!i2c_nack) begin
                        cnt_n   = '0;
                        state_n = S_SLEEP;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_n = retry_q + RW'(1);
                        state_n = S_WRITE;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_SLEEP: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (dly_end) begin
                    if (last_byte) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx_q + ROM_AW'(1);
                        addr_n  = addr_q + ROM_AW'(1);
                        retry_n = '0;
                        state_n = S_FETCH;
                    end
                end else begin
                    cnt_n = cnt_q + DELAY_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            S_ERR: begin
                error   = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign rom_addr     = addr_q;
    assign i2c_data     = data_q;
    assign i2c_reg_addr = CTRL_BYTE;
    assign active_seq   = seq_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: directed bench for i2c_cmd_seq with a ROM model and an
// i2c_master model that answers 20 cycles after each write request.
module tb_i2c_cmd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  trig = '0;
    logic        abort = 1'b0;
    logic [15:0] seq_base = '0;
    logic [15:0] seq_len = '0;
    logic        rom_rd_en;
    logic [3:0]  rom_addr;
    logic [7:0]  rom_data = '0;
    logic        i2c_write_en;
    logic [7:0]  i2c_reg_addr;
    logic [7:0]  i2c_data;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        busy;
    logic [1:0]  active_seq;
    logic        done;
    logic        error;

    i2c_cmd_seq #(
        .NUM_SEQ   (4),
        .ROM_AW    (4),
        .DELAY_W   (16),
        .DELAY_CYC (4),
        .MAX_RETRY (2),
        .CTRL_BYTE (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .trig         (trig),
        .abort        (abort),
        .seq_base     (seq_base),
        .seq_len      (seq_len),
        .rom_rd_en    (rom_rd_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .i2c_write_en (i2c_write_en),
        .i2c_reg_addr (i2c_reg_addr),
        .i2c_data     (i2c_data),
        .i2c_done     (i2c_done),
        .i2c_nack     (i2c_nack),
        .busy         (busy),
        .active_seq   (active_seq),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [16];

    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom[rom_addr];
    end

    // i2c_master model
    int wcnt = 0;
    int nack_left = 0;
    always @(negedge clk) begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (i2c_write_en) begin
            wcnt = 20;
        end else if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) begin
                i2c_done = 1'b1;
                if (nack_left > 0) begin
                    i2c_nack = 1'b1;
                    nack_left--;
                end
            end
        end
    end

    // event log
    int         cyc = 0;
    logic [7:0] wr_q [$];
    logic [1:0] ws_q [$];
    int         wc_q [$];
    logic [3:0] rd_q [$];
    int         rc_q [$];
    int         done_n = 0;
    int         err_n = 0;
    int         both_n = 0;
    int         done_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rom_rd_en) begin
            rd_q.push_back(rom_addr);
            rc_q.push_back(cyc);
        end
        if (i2c_write_en) begin
            wr_q.push_back(i2c_data);
            ws_q.push_back(active_seq);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (error) err_n++;
        if (done && error) both_n++;
    end

    task automatic clear_log();
        wr_q.delete();
        ws_q.delete();
        wc_q.delete();
        rd_q.delete();
        rc_q.delete();
    endtask

    task automatic set_script(input int i, input int b, input int l);
        seq_base[i*4 +: 4] = 4'(b);
        seq_len[i*4 +: 4]  = 4'(l);
    endtask

    task automatic pulse_trig(input logic [3:0] m);
        trig = trig | m;
        repeat (3) @(negedge clk);
        trig = trig & ~m;
    endtask

    task automatic wait_ends(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_n + err_n >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (wr_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        trig  = '0;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rom_rd_en, i2c_write_en, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 00000",
                     {busy, rom_rd_en, i2c_write_en, done, error});
        end
        checks++;
        if ({rom_addr, i2c_data, active_seq} !== 14'h0) begin
            errors++;
            $display("FAIL reset_regs got %h exp 0",
                     {rom_addr, i2c_data, active_seq});
        end
        checks++;
        if (i2c_reg_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %h exp 00", i2c_reg_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        logic [7:0] got;
        int base;
        int t0;
        bit ok;
        exp = '{8'hAE, 8'hD5, 8'h80};
        clear_log();
        base = done_n + err_n;
        t0 = cyc;
        pulse_trig(4'b0001);
        wait_ends(base + 1, 400, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout got none exp done");
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL basic_data[%0d] got %h exp %h",
                         i, got, exp[i]);
            end
        end
        checks++;
        if (wr_q.size() != 3) begin
            errors++;
            $display("FAIL basic_nwr got %0d exp 3", wr_q.size());
        end
        checks++;
        if (rc_q.size() < 1 || rc_q[0] - t0 != 4) begin
            errors++;
            $display("FAIL basic_latency got %0d exp 4",
                     rc_q.size() ? rc_q[0] - t0 : -1);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (wc_q.size() < 3 || wc_q[i] - wc_q[i-1] != 27) begin
                errors++;
                $display("FAIL basic_spacing[%0d] got %0d exp 27", i,
                         wc_q.size() >= 3 ? wc_q[i] - wc_q[i-1] : -1);
            end
        end
        checks++;
        if (done_n - base != 1 || err_n != 0) begin
            errors++;
            $display("FAIL basic_pulses got done %0d err %0d exp 1 0",
                     done_n - base, err_n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        logic [1:0] exs [3];
        logic [7:0] got;
        logic [1:0] gs;
        int base;
        bit ok;
        exp = '{8'h11, 8'h22, 8'h33};
        exs = '{2'd1, 2'd1, 2'd2};
        clear_log();
        base = done_n + err_n;
        pulse_trig(4'b0110);
        wait_ends(base + 2, 600, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout got none exp 2 dones");
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
            gs  = (i < ws_q.size()) ? ws_q[i] : 2'bxx;
            checks++;
            if (got !== exp[i] || gs !== exs[i]) begin
                errors++;
                $display("FAIL b2b_wr[%0d] got %h/%0d exp %h/%0d",
                         i, got, gs, exp[i], exs[i]);
            end
        end
        checks++;
        if (done_n + err_n - base != 2 || wr_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got %0d/%0d exp 2/3",
                     done_n + err_n - base, wr_q.size());
        end
    endtask

    task automatic test_nack();
        logic [7:0] exp [4];
        logic [7:0] got;
        int bd;
        int be;
        bit ok;
        exp = '{8'hA1, 8'hA1, 8'hA1, 8'hB2};
        clear_log();
        bd = done_n;
        be = err_n;
        nack_left = 2;
        pulse_trig(4'b1000);
        wait_ends(bd + be + 1, 600, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL nack_data[%0d] got %h exp %h",
                         i, got, exp[i]);
            end
        end
        checks++;
        if (wc_q.size() < 2 || wc_q[1] - wc_q[0] != 21) begin
            errors++;
            $display("FAIL nack_resend got %0d exp 21",
                     wc_q.size() >= 2 ? wc_q[1] - wc_q[0] : -1);
        end
        checks++;
        if (rd_q.size() != 2 || done_n - bd != 1 || err_n != be) begin
            errors++;
            $display("FAIL nack_ok got rd %0d done %0d err %0d exp 2 1 0",
                     rd_q.size(), done_n - bd, err_n - be);
        end

        clear_log();
        bd = done_n;
        be = err_n;
        nack_left = 3;
        pulse_trig(4'b1000);
        wait_ends(bd + be + 1, 600, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_q.size() != 3 || rd_q.size() != 1) begin
            errors++;
            $display("FAIL err_count got wr %0d rd %0d exp 3 1",
                     wr_q.size(), rd_q.size());
        end
        checks++;
        if (err_n - be != 1 || done_n != bd) begin
            errors++;
            $display("FAIL err_pulse got err %0d done %0d exp 1 0",
                     err_n - be, done_n - bd);
        end
        checks++;
        if (rom_addr !== 4'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_state got addr %0d busy %b exp 10 0",
                     rom_addr, busy);
        end
    endtask

    task automatic test_empty();
        int base;
        int t0;
        bit ok;
        set_script(0, 0, 0);
        clear_log();
        base = done_n + err_n;
        t0 = cyc;
        pulse_trig(4'b0001);
        wait_ends(base + 1, 50, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || done_cyc - t0 != 4) begin
            errors++;
            $display("FAIL empty_done got %0d exp 4", done_cyc - t0);
        end
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL empty_bus got rd %0d wr %0d exp 0 0",
                     rd_q.size(), wr_q.size());
        end
        set_script(0, 0, 3);
    endtask

    task automatic test_wrap();
        logic [3:0] ea [4];
        logic [7:0] ed [4];
        logic [3:0] ga;
        logic [7:0] gd;
        int base;
        bit ok;
        ea = '{4'd14, 4'd15, 4'd0, 4'd1};
        ed = '{8'hE0, 8'hF0, 8'hAE, 8'hD5};
        set_script(0, 14, 4);
        clear_log();
        base = done_n + err_n;
        pulse_trig(4'b0001);
        wait_ends(base + 1, 600, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ga = (i < rd_q.size()) ? rd_q[i] : 4'bxxxx;
            gd = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
            checks++;
            if (ga !== ea[i] || gd !== ed[i]) begin
                errors++;
                $display("FAIL wrap[%0d] got %0d/%h exp %0d/%h",
                         i, ga, gd, ea[i], ed[i]);
            end
        end
        set_script(0, 0, 3);
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp [3];
        logic [1:0] exs [3];
        logic [7:0] got;
        logic [1:0] gs;
        int bd;
        int be;
        int w;
        bit ok;
        exp = '{8'hAE, 8'hA1, 8'hB2};
        exs = '{2'd0, 2'd3, 2'd3};

        clear_log();
        bd = done_n;
        be = err_n;
        pulse_trig(4'b0001);
        wait_writes(1, 100, ok);
        pulse_trig(4'b1000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rom_rd_en, i2c_write_en, done, error} !== 5'b0 ||
            {rom_addr, i2c_data, active_seq} !== 14'h0) begin
            errors++;
            $display("FAIL midreset_out got %b %h exp 0 0",
                     {busy, rom_rd_en, i2c_write_en, done, error},
                     {rom_addr, i2c_data, active_seq});
        end
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        repeat (40) @(negedge clk);
        checks++;
        if (!ok || rd_q.size() != 0 || done_n != bd || err_n != be) begin
            errors++;
            $display("FAIL midreset_pend got rd %0d done %0d exp 0 0",
                     rd_q.size(), done_n - bd);
        end

        clear_log();
        pulse_trig(4'b0001);
        pulse_trig(4'b1000);
        wait_writes(1, 100, ok);
        w = (wc_q.size() > 0) ? wc_q[0] : cyc;
        while (cyc < w + 21) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done_n != bd) begin
            errors++;
            $display("FAIL abort_idle got busy %b done %0d exp 0 0",
                     busy, done_n - bd);
        end
        wait_ends(bd + be + 1, 600, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 8'hxx;
            gs  = (i < ws_q.size()) ? ws_q[i] : 2'bxx;
            checks++;
            if (got !== exp[i] || gs !== exs[i]) begin
                errors++;
                $display("FAIL abort_wr[%0d] got %h/%0d exp %h/%0d",
                         i, got, gs, exp[i], exs[i]);
            end
        end
        checks++;
        if (done_n - bd != 1 || err_n != be || both_n != 0) begin
            errors++;
            $display("FAIL abort_pulses got done %0d err %0d exp 1 0",
                     done_n - bd, err_n - be);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0]  = 8'hAE;
        rom[1]  = 8'hD5;
        rom[2]  = 8'h80;
        rom[4]  = 8'h11;
        rom[5]  = 8'h22;
        rom[8]  = 8'h33;
        rom[10] = 8'hA1;
        rom[11] = 8'hB2;
        rom[14] = 8'hE0;
        rom[15] = 8'hF0;
        set_script(0, 0, 3);
        set_script(1, 4, 2);
        set_script(2, 8, 1);
        set_script(3, 10, 2);

        test_reset();
        test_basic();
        test_back_to_back();
        test_nack();
        test_empty();
        test_wrap();
        test_reset_abort();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
